// File: rtl/seg7_scan_mux.sv
// Time-multiplexed driver for a common-anode multi-digit 7-segment display.
// A BCD word is accepted into a pending buffer through a valid/ready handshake
// and only copied into the display register at a frame boundary, so a frame
// never shows a mix of old and new digits. Each digit gets a guard period with
// all anodes off, then an ON period with its anode enabled.

module seg7_scan_mux #(
    parameter int unsigned NUM_DIGITS   = 3,
    parameter int unsigned ON_CYCLES    = 50000,
    parameter int unsigned GUARD_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid_i,
    output logic                    load_ready_o,
    input  logic [4*NUM_DIGITS-1:0] bcd_in_i,
    input  logic                    blank_lz_i,
    output logic [3:0]              digit_bcd_o,
    input  logic [6:0]              seg_in_i,
    output logic [6:0]              seg_o,
    output logic [NUM_DIGITS-1:0]   an_o
);

    localparam int unsigned DataW     = 4 * NUM_DIGITS;
    localparam int unsigned MaxCycles = (ON_CYCLES > GUARD_CYCLES) ? ON_CYCLES : GUARD_CYCLES;
    localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
    localparam int unsigned IdxW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [0:0] StGuard = 1'b0;
    localparam logic [0:0] StOn    = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [DataW-1:0] disp_q, disp_d;
    logic [DataW-1:0] pend_q, pend_d;
    logic            pend_full_q, pend_full_d;
    logic [6:0]      seg_q, seg_d;
    logic            frame_end;
    logic            blanked;

    // Scan sequencer: guard/on timing per digit and digit index advance.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        frame_end = 1'b0;
        case (state_q)
            StGuard: begin
                if (cnt_q == CntW'(GUARD_CYCLES - 1)) begin
                    state_d = StOn;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StOn: begin
                if (cnt_q == CntW'(ON_CYCLES - 1)) begin
                    state_d = StGuard;
                    cnt_d   = '0;
                    if (idx_q == IdxW'(NUM_DIGITS - 1)) begin
                        idx_d     = '0;
                        frame_end = 1'b1;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StGuard;
                cnt_d   = '0;
            end
        endcase
    end

    // Pending buffer fill on handshake; swap into the display only at frame end.
    // A full buffer holds ready low, so swap and capture never coincide.
    always_comb begin
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        disp_d      = disp_q;
        if (frame_end && pend_full_q) begin
            disp_d      = pend_q;
            pend_full_d = 1'b0;
        end else if (load_valid_i && !pend_full_q) begin
            pend_d      = bcd_in_i;
            pend_full_d = 1'b1;
        end
    end

    // Active nibble select and leading-zero blanking of the scanned digit.
    always_comb begin
        logic zero_above;
        digit_bcd_o = 4'h0;
        blanked     = 1'b0;
        zero_above  = 1'b1;
        for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
            zero_above = zero_above && (disp_q[4*k +: 4] == 4'h0);
            if (idx_q == IdxW'(k)) begin
                digit_bcd_o = disp_q[4*k +: 4];
                // Digit 0 is never blanked so a zero value still shows "0".
                if (k != 0 && zero_above) begin
                    blanked = blank_lz_i;
                end
            end
        end
    end

    // Decoder output is registered once so it settles during the guard period.
    assign seg_d        = ~seg_in_i;
    assign load_ready_o = ~pend_full_q;

    // Anode and segment drive; everything dark during guard or when blanked.
    always_comb begin
        an_o  = '1;
        seg_o = 7'h7F;
        if (state_q == StOn && !blanked) begin
            seg_o = seg_q;
            for (int k = 0; k < int'(NUM_DIGITS); k++) begin
                if (idx_q == IdxW'(k)) begin
                    an_o[k] = 1'b0;
                end
            end
        end
    end

    // State registers; reset discards any pending word and clears the display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StGuard;
            cnt_q       <= '0;
            idx_q       <= '0;
            disp_q      <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            seg_q       <= 7'h7F;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            disp_q      <= disp_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            seg_q       <= seg_d;
        end
    end

endmodule
